ram_strobe_master: RTL
======================

RAM_STROBE_MASTER -- requirements
Module: ram_strobe_master

Interface
REQ-001 Parameter SETUP_CYC, default 1, meaning clk cycles with ram_adr/ram_wri stable and ram_ena=0 before ram_ena rises; legal range 1..15.
REQ-002 Parameter PULSE_CYC, default 2, meaning clk cycles ram_ena is held high; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1, meaning clk cycles ram_adr/ram_wri/ram_wda stay stable after ram_ena falls; legal range 1..15.
REQ-004 clk  in  1  the only clock; all state changes occur on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  an access request is presented.
REQ-007 req_ready  out  1  the block accepts a request this cycle.
REQ-008 req_wr  in  1  1 selects write, 0 selects read.
REQ-009 req_adr  in  8  word address.
REQ-010 req_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  one-cycle pulse; rsp_rdata holds read data.
REQ-012 rsp_rdata  out  32  read data, held until the next read response.
REQ-013 init_busy  out  1  power-on clear sweep in progress.
REQ-014 ram_adr  out  8, ram_wri  out  1, ram_ena  out  1, ram_wda  out  32: registered strobe-side drive to the 256x32 RAM.
REQ-015 ram_rda  in  32  RAM read data, valid from PULSE_CYC-1 cycles after ram_ena rises.

Function
REQ-016 States: IDLE, SETUP, PULSE, HOLD; a 4-bit down-counter times SETUP, PULSE and HOLD.
REQ-017 req_ready is 1 only in IDLE with init_busy=0; handshake completes when req_valid and req_ready are both 1 at a rising edge.
REQ-018 On handshake: register req_adr/req_wr/req_wdata onto ram_adr/ram_wri/ram_wda and enter SETUP with ram_ena=0.
REQ-019 SETUP lasts SETUP_CYC cycles, then PULSE with ram_ena=1 for PULSE_CYC cycles, then HOLD with ram_ena=0 for HOLD_CYC cycles, then IDLE.
REQ-020 ram_adr, ram_wri and ram_wda do not change from the SETUP entry edge until the HOLD exit edge.
REQ-021 For reads, ram_rda is sampled into rsp_rdata at the edge ending the last PULSE cycle, and rsp_valid=1 during the first HOLD cycle only.
REQ-022 Writes produce no response; the RAM commits on the falling edge of ram_ena.
REQ-023 Read latency: rsp_valid is high SETUP_CYC+PULSE_CYC cycles after the handshake edge (default 3).
REQ-024 Occupancy is SETUP_CYC+PULSE_CYC+HOLD_CYC cycles plus one IDLE cycle; back-to-back throughput is one access per SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
REQ-025 In IDLE, ram_wri=0 and ram_ena=0; ram_adr and ram_wda hold their last value.
REQ-026 A request that arrives while req_ready=0 is neither dropped nor reordered; the requester holds it until accepted.

Reset
REQ-027 With rst_n=0 at an edge: state=IDLE; ram_ena, ram_wri, rsp_valid and req_ready are 0; ram_adr, ram_wda and rsp_rdata are 0; init_busy is 0 without RAM_STROBE_INIT_EN and 1 with it.
REQ-028 Reset during PULSE drops ram_ena and ram_wri at the same edge; the content of the addressed word is undefined afterwards; no response is issued.
REQ-029 req_ready is 0 in the first cycle after rst_n returns high.

Configuration
REQ-030 With RAM_STROBE_INIT_EN defined, after reset the block issues internal writes of 32'h0 to addresses 0..255 in ascending order using the REQ-019 timing, with init_busy=1 and req_ready=0 until the write to address 255 leaves HOLD.
REQ-031 Without RAM_STROBE_INIT_EN, init_busy is tied 0 and the block accepts requests from the second cycle after reset.

Structure
REQ-032 Package ram_strobe_pkg holds the state enum, ADR_W=8, DAT_W=32, CNT_W=4 and the RAM depth of 256.
REQ-033 One sub-module, ram_strobe_timer, holds the loadable 4-bit down-counter with a zero flag.

Verification
REQ-034 Default parameters, write adr 8'h05 data 32'hDEADBEEF: ram_ena is high for exactly 2 cycles; ram_adr=8'h05 and ram_wri=1 are stable 1 cycle before ram_ena rises and 1 cycle after it falls.
REQ-035 Read adr 8'h05 after REQ-034: rsp_valid pulses once, 3 cycles after the handshake, with rsp_rdata=32'hDEADBEEF.
REQ-036 req_valid held high for 3 back-to-back reads: each is accepted 5 cycles after the previous one, and exactly 3 rsp_valid pulses occur, in order.
REQ-037 SETUP_CYC=3, PULSE_CYC=4, HOLD_CYC=2: ram_ena high time is 4 cycles and read latency is 7 cycles.
REQ-038 rst_n=0 in the 2nd PULSE cycle of a write: ram_ena=0 and ram_wri=0 at the next edge, no rsp_valid, and req_ready=1 two cycles after rst_n=1.
REQ-039 With RAM_STROBE_INIT_EN: init_busy=1 for 256*5 cycles after reset; a subsequent read of adr 8'hFF returns 32'h0.

Source files
------------

// File: rtl/ram_strobe_pkg.sv
// Shared types and constants for the ram_strobe_master strobe-timed RAM access block.
package ram_strobe_pkg;

    localparam int ADR_W     = 8;
    localparam int DAT_W     = 32;
    localparam int CNT_W     = 4;
    localparam int RAM_DEPTH = 256;

    localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // A phase of N cycles is timed by loading N-1 and leaving when the counter reads zero.
    function automatic logic [CNT_W-1:0] cyc_to_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/ram_strobe_timer.sv
// Loadable down-counter that times the SETUP, PULSE and HOLD phases; zero flags phase end.
module ram_strobe_timer
    import ram_strobe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/ram_strobe_master.sv
// Strobe-timed master for a 256x32 asynchronous RAM: setup / enable pulse / hold sequencing.
// Optional feature macro RAM_STROBE_INIT_EN: zero-fill sweep of the whole RAM after reset.
module ram_strobe_master
    import ram_strobe_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [DAT_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [DAT_W-1:0] rsp_rdata,
    output logic             init_busy,
    output logic [ADR_W-1:0] ram_adr,
    output logic             ram_wri,
    output logic             ram_ena,
    output logic [DAT_W-1:0] ram_wda,
    input  logic [DAT_W-1:0] ram_rda
);

    localparam logic [CNT_W-1:0] SETUP_LD = cyc_to_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = cyc_to_load(PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = cyc_to_load(HOLD_CYC);

    state_t           state_r;
    logic             accept_s;
    logic             launch_init_s;
    logic             init_last_s;
    logic             init_busy_s;
    logic [ADR_W-1:0] init_adr_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;

    assign accept_s      = req_valid && req_ready;
    assign launch_init_s = (state_r == ST_IDLE) && init_busy_s;
    assign init_last_s   = init_busy_s && (state_r == ST_HOLD) && tmr_zero_s && (ram_adr == ADR_LAST);

`ifdef RAM_STROBE_INIT_EN
    logic             init_busy_r;
    logic [ADR_W-1:0] init_adr_r;

    // Sweep pointer advances per launched clear-write; busy drops as the last word leaves HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_busy_r <= 1'b1;
            init_adr_r  <= {ADR_W{1'b0}};
        end else if (launch_init_s) begin
            init_adr_r  <= init_adr_r + {{(ADR_W-1){1'b0}}, 1'b1};
        end else if (init_last_s) begin
            init_busy_r <= 1'b0;
        end else begin
            init_busy_r <= init_busy_r;
        end
    end

    assign init_busy_s = init_busy_r;
    assign init_adr_s  = init_adr_r;
`else
    assign init_busy_s = 1'b0;
    assign init_adr_s  = {ADR_W{1'b0}};
`endif

    assign init_busy = init_busy_s;

    // Timer reloads at the start of each phase; HOLD exit needs no reload.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = SETUP_LD;
        case (state_r)
            ST_IDLE: begin
                if (accept_s || launch_init_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_LD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PULSE_LD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_PULSE: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    ram_strobe_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Access sequencer; address, direction and write data are frozen from SETUP entry to HOLD exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b0;
            ram_ena   <= 1'b0;
            ram_wri   <= 1'b0;
            ram_adr   <= {ADR_W{1'b0}};
            ram_wda   <= {DAT_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_rdata <= {DAT_W{1'b0}};
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_init_s) begin
                        ram_adr   <= init_adr_s;
                        ram_wri   <= 1'b1;
                        ram_wda   <= {DAT_W{1'b0}};
                        req_ready <= 1'b0;
                        state_r   <= ST_SETUP;
                    end else if (accept_s) begin
                        ram_adr   <= req_adr;
                        ram_wri   <= req_wr;
                        ram_wda   <= req_wdata;
                        req_ready <= 1'b0;
                        state_r   <= ST_SETUP;
                    end else begin
                        req_ready <= !init_busy_s;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero_s) begin
                        ram_ena <= 1'b1;
                        state_r <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_zero_s) begin
                        ram_ena <= 1'b0;
                        state_r <= ST_HOLD;
                        if (!ram_wri) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= ram_rda;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero_s) begin
                        ram_wri   <= 1'b0;
                        req_ready <= !init_busy_s || init_last_s;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    ram_ena   <= 1'b0;
                    ram_wri   <= 1'b0;
                    req_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
